// File: rtl/snake_tile_map_if.sv
// snake_tile_map_if
//   Avalon-MM slave bus between the HPS bridge and the tile map.
//   master : drives chipselect/write/read/address/writedata, samples readdata
//   slave  : samples the strobes and data, drives readdata
interface snake_tile_map_if;
    logic       chipselect;
    logic       write;
    logic       read;
    logic [2:0] address;
    logic [7:0] writedata;
    logic [7:0] readdata;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata
    );
endinterface

// File: rtl/snake_tile_map.sv
// snake_tile_map
//   Double-buffered 40x30 tile map (16x16-pixel tiles). Software fills the
//   back bank through the Avalon registers. The renderer reads the front bank
//   from hcount/vcount. Banks swap only at the start of vertical blank, so the
//   playfield never tears.
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   bus          Avalon slave: COL(0) ROW(1) TILE(2) CTRL(3) STATUS(4)
//   hcount       horizontal count (hcount[10:1] = pixel column)
//   vcount       vertical count
//   tile_code    front-bank code for the pixel, 2 clk after hcount/vcount
//   sprite_addr  {vcount[3:0],hcount[4:1]}, 2 clk after hcount/vcount
//   tile_valid   delayed pixel lies in the active area
//   busy         INIT or CLEAR sweep in progress
module snake_tile_map #(
    parameter int COLS   = 40,
    parameter int ROWS   = 30,
    parameter int CODE_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    snake_tile_map_if.slave     bus,
    input  logic [10:0]         hcount,
    input  logic [9:0]          vcount,
    output logic [CODE_W-1:0]   tile_code,
    output logic [7:0]          sprite_addr,
    output logic                tile_valid,
    output logic                busy
);
    localparam logic [1:0]  ST_INIT  = 2'd0;
    localparam logic [1:0]  ST_IDLE  = 2'd1;
    localparam logic [1:0]  ST_CLEAR = 2'd2;

    localparam int          DEPTH    = COLS * ROWS;
    localparam logic [10:0] LAST_IDX = 11'(DEPTH - 1);
    localparam logic [5:0]  COLS_W   = 6'(COLS);
    localparam logic [4:0]  ROWS_W   = 5'(ROWS);
    // hcount runs at twice the pixel rate, hence 32 counts per tile column.
    localparam logic [10:0] H_ACTIVE = 11'(COLS * 32);
    localparam logic [9:0]  V_ACTIVE = 10'(ROWS * 16);

    logic [1:0]        state_q, state_d;
    logic [10:0]       sweep_idx_q, sweep_idx_d;
    logic [5:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic              front_q, front_d;
    logic              swap_pending_q, swap_pending_d;
    logic [7:0]        readdata_q, readdata_d;

    logic [10:0]       s1_idx_q, s1_idx_d;
    logic [7:0]        s1_off_q, s1_off_d;
    logic              s1_active_q, s1_active_d;
    logic              s1_front_q;
    logic [7:0]        s2_off_q;
    logic              s2_active_q;
    logic              s2_front_q;

    logic              bus_wr, bus_rd, busy_int, back_sel;
    logic              tile_we, commit_req, clear_req, vblank_start;
    logic [10:0]       tile_idx, wr_addr;
    logic [CODE_W-1:0] wr_data;
    logic [1:0][CODE_W-1:0] bank_rd;

    assign bus_wr       = bus.chipselect & bus.write;
    assign bus_rd       = bus.chipselect & bus.read;
    assign busy_int     = (state_q != ST_IDLE);
    assign back_sel     = ~front_q;
    assign tile_idx     = 11'(row_q) * 11'(COLS) + 11'(col_q);
    assign tile_we      = bus_wr && (bus.address == 3'd2) && !busy_int &&
                          (col_q < COLS_W) && (row_q < ROWS_W);
    assign commit_req   = bus_wr && (bus.address == 3'd3) && bus.writedata[0];
    assign clear_req    = bus_wr && (bus.address == 3'd3) && bus.writedata[1];
    assign vblank_start = (hcount == 11'd0) && (vcount == V_ACTIVE);

    // Sweeps own the write port while busy; TILE writes are blocked then anyway.
    assign wr_addr = busy_int ? sweep_idx_q : tile_idx;
    assign wr_data = busy_int ? '0 : bus.writedata[CODE_W-1:0];

    // Sweep FSM
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        case (state_q)
            ST_INIT, ST_CLEAR: begin
                if (sweep_idx_q == LAST_IDX) begin
                    state_d     = ST_IDLE;
                    sweep_idx_d = '0;
                end else begin
                    sweep_idx_d = sweep_idx_q + 11'd1;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_d     = ST_CLEAR;
                    sweep_idx_d = '0;
                end
            end
            default: begin
                state_d     = ST_INIT;
                sweep_idx_d = '0;
            end
        endcase
    end

    // Register file, cursor and bank swap
    always_comb begin
        col_d          = col_q;
        row_d          = row_q;
        front_d        = front_q;
        swap_pending_d = swap_pending_q;
        readdata_d     = readdata_q;

        if (bus_wr && bus.address == 3'd0) col_d = bus.writedata[5:0];
        if (bus_wr && bus.address == 3'd1) row_d = bus.writedata[4:0];
        if (tile_we) begin
            if (col_q == COLS_W - 6'd1) begin
                col_d = '0;
                row_d = (row_q == ROWS_W - 5'd1) ? 5'd0 : row_q + 5'd1;
            end else begin
                col_d = col_q + 6'd1;
            end
        end

        if (vblank_start && swap_pending_q && !busy_int) begin
            front_d        = ~front_q;
            swap_pending_d = 1'b0;
        end
        // A COMMIT landing on the swap clock re-arms for the next frame.
        if (commit_req) swap_pending_d = 1'b1;

        if (bus_rd) begin
            case (bus.address)
                3'd0:    readdata_d = {2'b00, col_q};
                3'd1:    readdata_d = {3'b000, row_q};
                3'd4:    readdata_d = {5'b00000, front_q, swap_pending_q, busy_int};
                default: readdata_d = 8'h00;
            endcase
        end
    end

    // Render stage 1: tile index, pixel offset inside the tile, active flag
    always_comb begin
        s1_active_d = (hcount < H_ACTIVE) && (vcount < V_ACTIVE);
        s1_off_d    = {vcount[3:0], hcount[4:1]};
        s1_idx_d    = s1_active_d ? 11'(vcount[9:4]) * 11'(COLS) + 11'(hcount[10:5]) : 11'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_INIT;
            sweep_idx_q    <= '0;
            col_q          <= '0;
            row_q          <= '0;
            front_q        <= 1'b0;
            swap_pending_q <= 1'b0;
            readdata_q     <= '0;
            s1_idx_q       <= '0;
            s1_off_q       <= '0;
            s1_active_q    <= 1'b0;
            s1_front_q     <= 1'b0;
            s2_off_q       <= '0;
            s2_active_q    <= 1'b0;
            s2_front_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sweep_idx_q    <= sweep_idx_d;
            col_q          <= col_d;
            row_q          <= row_d;
            front_q        <= front_d;
            swap_pending_q <= swap_pending_d;
            readdata_q     <= readdata_d;
            s1_idx_q       <= s1_idx_d;
            s1_off_q       <= s1_off_d;
            s1_active_q    <= s1_active_d;
            s1_front_q     <= front_q;
            s2_off_q       <= s1_off_q;
            s2_active_q    <= s1_active_q;
            s2_front_q     <= s1_front_q;
        end
    end

    // Render stage 2: both banks read every clock, front chosen afterwards.
    // INIT writes both banks; CLEAR and TILE writes go to the back bank.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [CODE_W-1:0] mem [0:DEPTH-1];
            logic [CODE_W-1:0] rd_q;
            logic              we;

            assign we = (state_q == ST_INIT) ||
                        (((state_q == ST_CLEAR) || tile_we) && (back_sel == 1'(gi)));

            always_ff @(posedge clk) begin
                if (we) mem[wr_addr] <= wr_data;
                rd_q <= mem[s1_idx_q];
            end

            assign bank_rd[gi] = rd_q;
        end
    endgenerate

    // The RAM read registers have no reset; gating by the reset-cleared
    // active flag keeps tile_code at 0 during and right after reset.
    assign tile_code    = s2_active_q ? bank_rd[s2_front_q] : '0;
    assign sprite_addr  = s2_off_q;
    assign tile_valid   = s2_active_q;
    assign busy         = busy_int;
    assign bus.readdata = readdata_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.writedata[7:6], hcount[0]};
endmodule

// File: tb/tb_snake_tile_map.sv
module tb_snake_tile_map;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [3:0]  tile_code;
    logic [7:0]  sprite_addr;
    logic        tile_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    snake_tile_map_if bus ();

    snake_tile_map dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .hcount      (hcount),
        .vcount      (vcount),
        .tile_code   (tile_code),
        .sprite_addr (sprite_addr),
        .tile_valid  (tile_valid),
        .busy        (busy)
    );

    // Reference model: map contents and register state, from the written rules
    int m_bank [2][1200];
    int m_col, m_row, m_front, m_pending, m_busy_left;

    typedef struct {
        logic [3:0] code;
        logic [7:0] sa;
        logic       valid;
    } pix_t;
    pix_t pq[$];

    localparam int IDLE_H = 1300;
    localparam int IDLE_V = 500;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[%0t] FAIL %s: got 0x%0h expected 0x%0h", $time, tag, got, exp);
        end else begin
            $display("[%0t] ok   %s: 0x%0h", $time, tag, got);
        end
    endtask

    function automatic void model_reset();
        m_col = 0; m_row = 0; m_front = 0; m_pending = 0; m_busy_left = 1200;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 1200; i++) m_bank[b][i] = 0;
    endfunction

    // Effect of one rising edge given the inputs currently driven
    function automatic void model_edge();
        bit busy_now;
        if (!reset_n) begin
            model_reset();
            return;
        end
        busy_now = (m_busy_left != 0);
        if (busy_now) m_busy_left--;
        if (bus.chipselect && bus.write) begin
            case (bus.address)
                3'd0: m_col = int'(bus.writedata[5:0]);
                3'd1: m_row = int'(bus.writedata[4:0]);
                3'd2: if (!busy_now && m_col < 40 && m_row < 30) begin
                    m_bank[1 - m_front][m_row * 40 + m_col] = int'(bus.writedata[3:0]);
                    m_col++;
                    if (m_col == 40) begin
                        m_col = 0;
                        m_row = (m_row == 29) ? 0 : m_row + 1;
                    end
                end
                default: ;
            endcase
        end
        if (hcount == 0 && vcount == 480 && m_pending == 1 && !busy_now) begin
            m_front   = 1 - m_front;
            m_pending = 0;
        end
        if (bus.chipselect && bus.write && bus.address == 3'd3) begin
            if (bus.writedata[1] && !busy_now) begin
                m_busy_left = 1200;
                for (int i = 0; i < 1200; i++) m_bank[1 - m_front][i] = 0;
            end
            if (bus.writedata[0]) m_pending = 1;
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int addr, input int data);
        bus.chipselect = 1'b1; bus.write = 1'b1;
        bus.address = 3'(addr); bus.writedata = 8'(data);
        step();
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic read_check(input string tag, input int addr);
        int exp;
        case (addr)
            0:       exp = m_col;
            1:       exp = m_row;
            4:       exp = (m_front << 2) | (m_pending << 1) | ((m_busy_left != 0) ? 1 : 0);
            default: exp = 0;
        endcase
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 3'(addr);
        step();
        bus.chipselect = 1'b0; bus.read = 1'b0;
        check_eq(tag, 32'(bus.readdata), 32'(exp));
        check_eq({tag, "_busy"}, 32'(busy), (m_busy_left != 0) ? 32'd1 : 32'd0);
    endtask

    task automatic vblank();
        hcount = 11'd0; vcount = 10'd480;
        step();
        hcount = 11'(IDLE_H); vcount = 10'(IDLE_V);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 5000) begin
            step();
            n++;
        end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    // Streams n pixels (random when fh<0) and checks each one 2 clk later
    task automatic render_run(input int n, input int fh, input int fv);
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                int h, v;
                pix_t p;
                if (fh >= 0) begin
                    h = fh; v = fv;
                end else if ($urandom_range(0, 3) != 0) begin
                    h = $urandom_range(0, 1279); v = $urandom_range(0, 479);
                end else begin
                    h = $urandom_range(0, 2047); v = $urandom_range(0, 1023);
                end
                if (h == 0 && v == 480) h = 2;
                hcount = 11'(h); vcount = 10'(v);
                p.valid = (h < 1280 && v < 480);
                p.sa    = 8'(((v % 16) << 4) | ((h / 2) % 16));
                p.code  = p.valid ? 4'(m_bank[m_front][(v / 16) * 40 + (h / 32)]) : 4'd0;
                pq.push_back(p);
            end else begin
                hcount = 11'(IDLE_H); vcount = 10'(IDLE_V);
            end
            step();
            if (pq.size() == 2 || (i == n && pq.size() > 0)) begin
                pix_t e = pq.pop_front();
                check_eq("pix_code",  32'(tile_code),   32'(e.code));
                check_eq("pix_saddr", 32'(sprite_addr), 32'(e.sa));
                check_eq("pix_valid", 32'(tile_valid),  32'(e.valid));
            end
        end
    endtask

    initial begin
        int n;
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
        bus.address = 3'd0; bus.writedata = 8'd0;
        hcount = 11'(IDLE_H); vcount = 10'(IDLE_V);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_readdata", 32'(bus.readdata), 32'd0);
        check_eq("rst_tile_code", 32'(tile_code), 32'd0);
        check_eq("rst_sprite_addr", 32'(sprite_addr), 32'd0);
        check_eq("rst_tile_valid", 32'(tile_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd1);
        step();
        step();
        reset_n = 1'b1;

        // INIT sweep length
        n = 0;
        while (busy && n < 5000) begin
            step();
            n++;
        end
        check_eq("init_cycles", 32'(n), 32'd1200);
        read_check("status_after_init", 4);
        render_run(16, -1, -1);

        // Cursor write and auto-increment across a row boundary
        bus_write(0, 39);
        bus_write(1, 2);
        bus_write(2, 1);
        bus_write(2, 14);
        read_check("col_after_wrap", 0);
        check_eq("col_const", 32'(bus.readdata), 32'd1);
        read_check("row_after_wrap", 1);
        check_eq("row_const", 32'(bus.readdata), 32'd3);

        // Commit mid-frame: no swap until vblank start
        bus_write(3, 1);
        hcount = 11'd0; vcount = 10'd479;
        step();
        hcount = 11'(IDLE_H); vcount = 10'(IDLE_V);
        read_check("status_pre_vblank", 4);
        check_eq("front_still0", 32'(bus.readdata), 32'h02);
        vblank();
        read_check("status_post_vblank", 4);
        check_eq("front_now1", 32'(bus.readdata), 32'h04);
        hcount = 11'd1248; vcount = 10'd32;
        step();
        step();
        check_eq("tile_39_2", 32'(tile_code), 32'd1);
        check_eq("tile_39_2_valid", 32'(tile_valid), 32'd1);
        render_run(2, 0, 48);

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            int r = $urandom_range(0, 99);
            if (r < 8)       bus_write(0, $urandom_range(0, 42));
            else if (r < 14) bus_write(1, $urandom_range(0, 31));
            else if (r < 48) bus_write(2, $urandom_range(0, 15));
            else if (r < 56) bus_write(3, 1);
            else if (r < 66) vblank();
            else if (r < 84) render_run($urandom_range(1, 8), -1, -1);
            else if (r < 90) read_check("rand_status", 4);
            else if (r < 93) read_check("rand_col", 0);
            else if (r < 96) read_check("rand_row", 1);
            else if (r < 98) read_check("rand_unmapped", $urandom_range(5, 7));
            else             bus_write(3, 2);
        end

        // Full-map stream wraps the cursor back to the origin
        wait_idle("idle_before_stream");
        bus_write(0, 0);
        bus_write(1, 0);
        for (int i = 0; i < 1200; i++) bus_write(2, $urandom_range(0, 15));
        read_check("stream_col", 0);
        check_eq("stream_col_zero", 32'(bus.readdata), 32'd0);
        read_check("stream_row", 1);
        check_eq("stream_row_zero", 32'(bus.readdata), 32'd0);
        bus_write(0, 40);
        bus_write(2, 7);
        read_check("oob_col", 0);
        check_eq("oob_col_40", 32'(bus.readdata), 32'd40);
        read_check("oob_row", 1);
        bus_write(3, 1);
        vblank();
        render_run(40, -1, -1);

        // CLEAR with a COMMIT during the sweep
        vblank();
        bus_write(0, 3);
        bus_write(1, 4);
        bus_write(3, 2);
        bus_write(2, 9);
        read_check("clear_col_held", 0);
        bus_write(3, 1);
        vblank();
        read_check("clear_no_swap", 4);
        wait_idle("idle_after_clear");
        read_check("clear_pending", 4);
        vblank();
        read_check("clear_swapped", 4);
        render_run(40, -1, -1);

        // Reset in the middle of a CLEAR sweep
        bus_write(3, 2);
        hcount = 11'd100; vcount = 10'd100;
        for (int i = 0; i < 100; i++) step();
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 3'd4;
        step();
        bus.chipselect = 1'b0; bus.read = 1'b0;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_readdata", 32'(bus.readdata), 32'd0);
        check_eq("mid_rst_tile_code", 32'(tile_code), 32'd0);
        check_eq("mid_rst_sprite_addr", 32'(sprite_addr), 32'd0);
        check_eq("mid_rst_tile_valid", 32'(tile_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd1);
        hcount = 11'(IDLE_H); vcount = 10'(IDLE_V);
        step();
        reset_n = 1'b1;
        read_check("restart_status", 4);
        check_eq("restart_front0", 32'(bus.readdata), 32'h01);
        wait_idle("idle_after_restart");
        read_check("final_status", 4);
        render_run(16, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
